// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, fetch-address check and IF/ID register.
// Also keeps a free-running count of instructions accepted into IF/ID.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] next_PC,
  input  logic [31:0] F_instr,
  output logic [31:0] F_PC,
  output logic [31:0] D_PC,
  output logic [31:0] D_instr,
  output logic [31:0] D_PC8,
  output logic        D_valid,
  output logic        D_fault,
  output logic [31:0] fetch_count
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        fault;
  } if_id_t;

  localparam if_id_t BUBBLE = '{
    pc: 32'd0, instr: 32'd0, valid: 1'b0, fault: 1'b0
  };

  // 33-bit bound so a region ending at 4 GiB cannot wrap to zero
  localparam logic [32:0] IM_END =
    {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  logic [31:0] pc;
  if_id_t      d;
  logic        addr_bad;
  logic [31:0] fetched;
  if_id_t      d_fetch;

  assign addr_bad = (pc[1:0] != 2'b00)
                  | (pc < IM_BASE)
                  | ({1'b0, pc} >= IM_END);

  assign fetched = addr_bad ? 32'h0000_0000 : F_instr;

  always_comb begin
    d_fetch       = BUBBLE;
    d_fetch.pc    = pc;
    d_fetch.instr = fetched;
    d_fetch.valid = 1'b1;
    d_fetch.fault = addr_bad;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= PC_RESET;
      d           <= BUBBLE;
      fetch_count <= 32'd0;
    end else begin
      unique case (1'b1)
        stall && flush: begin
          d <= BUBBLE;
        end
        stall && !flush: ;
        flush && !stall: begin
          pc <= next_PC;
          d  <= BUBBLE;
        end
        default: begin
          pc          <= next_PC;
          d           <= d_fetch;
          fetch_count <= fetch_count + 32'd1;
        end
      endcase
    end
  end

  assign F_PC    = pc;
  assign D_PC    = d.pc;
  assign D_instr = d.instr;
  assign D_valid = d.valid;
  assign D_fault = d.fault;
  assign D_PC8   = d.pc + 32'd8;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a reference model pushes the expected
// post-edge state at drive time; it is popped and compared after the edge.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] next_PC;
  logic [31:0] F_instr;
  logic [31:0] F_PC;
  logic [31:0] D_PC;
  logic [31:0] D_instr;
  logic [31:0] D_PC8;
  logic        D_valid;
  logic        D_fault;
  logic [31:0] fetch_count;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .next_PC     (next_PC),
    .F_instr     (F_instr),
    .F_PC        (F_PC),
    .D_PC        (D_PC),
    .D_instr     (D_instr),
    .D_PC8       (D_PC8),
    .D_valid     (D_valid),
    .D_fault     (D_fault),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory returns the address as data
  assign F_instr = F_PC;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] dpc;
    logic [31:0] dinstr;
    logic        dval;
    logic        dfault;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [31:0] m_pc;
  logic [31:0] m_dpc;
  logic [31:0] m_dinstr;
  logic        m_dval;
  logic        m_dfault;
  logic [31:0] m_cnt;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < 32'h0000_3000)
        || (a >= 32'h0000_7000);
  endfunction

  task automatic cyc(input logic r, input logic s,
                     input logic f, input logic [31:0] npc);
    exp_t e;
    logic b;
    @(negedge clk);
    reset   = r;
    stall   = s;
    flush   = f;
    next_PC = npc;
    if (r) begin
      m_pc = 32'h0000_3000;
      m_dpc = 0; m_dinstr = 0; m_dval = 0; m_dfault = 0;
      m_cnt = 0;
    end else begin
      b = bad_addr(m_pc);
      if (f) begin
        m_dpc = 0; m_dinstr = 0; m_dval = 0; m_dfault = 0;
      end else if (!s) begin
        m_dpc    = m_pc;
        m_dinstr = b ? 32'd0 : m_pc;
        m_dval   = 1'b1;
        m_dfault = b;
        m_cnt    = m_cnt + 32'd1;
      end
      if (!s) m_pc = npc;
    end
    e = '{m_pc, m_dpc, m_dinstr, m_dval, m_dfault, m_cnt};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("F_PC",    F_PC,          e.pc);
    chk("D_PC",    D_PC,          e.dpc);
    chk("D_instr", D_instr,       e.dinstr);
    chk("D_PC8",   D_PC8,         e.dpc + 32'd8);
    chk("D_valid", 32'(D_valid),  32'(e.dval));
    chk("D_fault", 32'(D_fault),  32'(e.dfault));
    chk("count",   fetch_count,   e.cnt);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, m_pc + 32'd4);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; next_PC = 32'd0;
    m_pc = 32'h3000; m_dpc = 0; m_dinstr = 0;
    m_dval = 0; m_dfault = 0; m_cnt = 0;

    cyc(1'b1, 1'b0, 1'b0, 32'h1234);
    cyc(1'b1, 1'b0, 1'b0, 32'h1234);
    chk("rst_fpc",  F_PC,  32'h0000_3000);
    chk("rst_dpc8", D_PC8, 32'd8);

    run(3);
    chk("seq_fpc", F_PC,        32'h0000_300C);
    chk("seq_dpc", D_PC,        32'h0000_3008);
    chk("seq_cnt", fetch_count, 32'd3);

    cyc(1'b0, 1'b1, 1'b0, m_pc + 32'd4);
    cyc(1'b0, 1'b1, 1'b0, m_pc + 32'd8);
    chk("stall_fpc", F_PC,        32'h0000_300C);
    chk("stall_cnt", fetch_count, 32'd3);
    run(1);
    chk("resume_fpc", F_PC, 32'h0000_3010);

    cyc(1'b0, 1'b0, 1'b1, 32'h0000_3040);
    chk("flush_fpc", F_PC,            32'h0000_3040);
    chk("flush_val", 32'(D_valid),    32'd0);
    run(1);
    cyc(1'b0, 1'b1, 1'b1, 32'h0000_5000);
    chk("fs_fpc", F_PC,         32'h0000_3044);
    chk("fs_val", 32'(D_valid), 32'd0);

    cyc(1'b0, 1'b0, 1'b0, 32'h0000_3002);
    cyc(1'b0, 1'b0, 1'b0, 32'h0000_2FFC);
    chk("mis_fault", 32'(D_fault), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0000_7000);
    chk("low_fault", 32'(D_fault), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0000_6FFC);
    chk("top_fault", 32'(D_fault), 32'd1);
    chk("top_instr", D_instr,      32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0000_3ABC);
    chk("last_ok", 32'(D_fault), 32'd0);

    cyc(1'b0, 1'b0, 1'b0, 32'h0000_3AC0);
    chk("jmp_dpc",  D_PC,  32'h0000_3ABC);
    chk("jmp_dpc8", D_PC8, 32'h0000_3AC4);

    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    run(5);
    cyc(1'b0, 1'b1, 1'b0, m_pc + 32'd4);
    chk("pre_cnt", fetch_count, 32'd5);
    cyc(1'b1, 1'b1, 1'b0, m_pc + 32'd4);
    chk("mid_fpc", F_PC,        32'h0000_3000);
    chk("mid_cnt", fetch_count, 32'd0);

    run(1);
    force dut.fetch_count = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_count;
    #1;
    m_cnt = 32'hFFFF_FFFF;
    chk("wrap_pre", fetch_count, 32'hFFFF_FFFF);
    run(1);
    chk("wrap_cnt", fetch_count, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
